// File: rtl/lamp_seq_monitor.sv
// ---------------------------------------------------------------------------
// lamp_seq_monitor
//
// Watches a thermometer-coded lamp bus and checks that it follows the
// expected up/down light-chase sequence: three rise/fall legs (A, B, C)
// with optional "kickbacks" requested through flick. Any bad sample sends
// the monitor into SYNC until the bus goes dark, then it re-arms in IDLE.
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   lamp      observed lamp bus (MX_LP bits), sampled every rising edge
//   flick     observed flick request, sampled with lamp
//   clr       synchronous clear of counters, err_flag and err_code
//   phase     decoded phase (IDLE=0 .. SYNC=7)
//   obs_n     lit-lamp count of the last sample
//   exp_n     predicted lit-lamp count for the next sample
//   err       one-cycle error pulse
//   err_code  {step, shape} of the most recent error, held until next/clr
//   err_flag  sticky error indicator
//   seq_cnt   completed sequences (saturating)
//   kick_cnt  kickbacks taken (saturating)
//   err_cnt   errors seen (saturating)
// ---------------------------------------------------------------------------
module lamp_seq_monitor #(
  parameter int MX_LP = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MX_LP-1:0] lamp,
  input  logic             flick,
  input  logic             clr,
  output logic [2:0]       phase,
  output logic [4:0]       obs_n,
  output logic [4:0]       exp_n,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             err_flag,
  output logic [7:0]       seq_cnt,
  output logic [7:0]       kick_cnt,
  output logic [7:0]       err_cnt
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP_A = 3'd1,
    DN_A = 3'd2,
    UP_B = 3'd3,
    DN_B = 3'd4,
    UP_C = 3'd5,
    DN_C = 3'd6,
    SYNC = 3'd7
  } phase_t;

  phase_t           state;
  logic [4:0]       n_now;
  logic [MX_LP-1:0] lamp_inc;
  logic             legal;
  logic             shape_err;
  logic             step_err;
  logic             any_err;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Count the lit lamps in the current sample. For a legal thermometer
  // code this is exactly n, and for an illegal shape it is the popcount
  // that gets reported, so one adder tree serves both cases.
  always_comb begin
    n_now = '0;
    for (int i = 0; i < MX_LP; i++) begin
      n_now = n_now + {4'b0000, lamp[i]};
    end
  end

  // A thermometer code 2^n-1 is the only pattern where adding one clears
  // every set bit; all-ones wraps to zero, which also passes.
  assign lamp_inc = lamp + MX_LP'(1);
  assign legal    = ((lamp & lamp_inc) == '0);

  // Checking is suspended in SYNC; everywhere else both the shape and the
  // predicted count are enforced against the current sample.
  always_comb begin
    shape_err = (state != SYNC) && !legal;
    step_err  = (state != SYNC) && (n_now != exp_n);
    any_err   = shape_err || step_err;
  end

  assign phase = state;

  // Main sequencer. Every output is a register updated from the sample
  // taken on this edge. An error overrides the sequence walk and parks the
  // monitor in SYNC. Otherwise the phase/prediction step is taken from the
  // current phase and count; since no error occurred, n_now equals exp_n
  // here, so the turn-around points are plain equality tests. clr is
  // handled last so it overrides the seq/kick increments, while an error in
  // the same cycle still reports itself with err_cnt restarting at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      exp_n    <= '0;
      obs_n    <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
      err_flag <= 1'b0;
      seq_cnt  <= '0;
      kick_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      obs_n <= n_now;
      err   <= any_err;

      if (any_err) begin
        state    <= SYNC;
        exp_n    <= '0;
        err_code <= {step_err, shape_err};
        err_flag <= 1'b1;
        err_cnt  <= clr ? 8'd1 : sat_inc(err_cnt);
      end else begin
        if (clr) begin
          err_code <= 2'b00;
          err_flag <= 1'b0;
          err_cnt  <= '0;
        end
        case (state)
          IDLE: begin
            if (flick) begin
              state <= UP_A;
              exp_n <= 5'd1;
            end else begin
              exp_n <= 5'd0;
            end
          end
          UP_A: begin
            if (n_now == 5'(MX_LP)) begin
              state <= DN_A;
              exp_n <= 5'(MX_LP - 1);
            end else begin
              exp_n <= n_now + 5'd1;
            end
          end
          DN_A: begin
            if (n_now == 5'd6) begin
              exp_n <= 5'd7;
              if (flick) begin
                state    <= UP_A;
                kick_cnt <= sat_inc(kick_cnt);
              end else begin
                state <= UP_B;
              end
            end else begin
              exp_n <= n_now - 5'd1;
            end
          end
          UP_B: begin
            if (n_now == 5'd11) begin
              state <= DN_B;
              exp_n <= 5'd10;
            end else begin
              exp_n <= n_now + 5'd1;
            end
          end
          DN_B: begin
            // Two places to kick back up into leg B: mid-way at five lamps,
            // or at the bottom. Without flick the bottom leads into leg C.
            if (n_now == 5'd5 && flick) begin
              state    <= UP_B;
              exp_n    <= 5'd6;
              kick_cnt <= sat_inc(kick_cnt);
            end else if (n_now == 5'd0) begin
              exp_n <= 5'd1;
              if (flick) begin
                state    <= UP_B;
                kick_cnt <= sat_inc(kick_cnt);
              end else begin
                state <= UP_C;
              end
            end else begin
              exp_n <= n_now - 5'd1;
            end
          end
          UP_C: begin
            if (n_now == 5'd6) begin
              state <= DN_C;
              exp_n <= 5'd5;
            end else begin
              exp_n <= n_now + 5'd1;
            end
          end
          DN_C: begin
            if (n_now == 5'd0) begin
              state   <= IDLE;
              exp_n   <= 5'd0;
              seq_cnt <= sat_inc(seq_cnt);
            end else begin
              exp_n <= n_now - 5'd1;
            end
          end
          SYNC: begin
            if (lamp == '0) begin
              state <= IDLE;
              exp_n <= 5'd0;
            end
          end
          default: begin
            state <= SYNC;
            exp_n <= 5'd0;
          end
        endcase
      end

      if (clr) begin
        seq_cnt  <= '0;
        kick_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lamp_seq_monitor.sv
// ---------------------------------------------------------------------------
// tb_lamp_seq_monitor
//
// Self-checking bench for lamp_seq_monitor. A table of golden-sequence
// vectors with hand-derived expectations, directed sequences for kickback,
// error, clear, saturation and asynchronous reset corners, and a long
// randomized run compared every cycle against a leg-table reference model.
// ---------------------------------------------------------------------------
module tb_lamp_seq_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] lamp = '0;
  logic        flick = 1'b0;
  logic        clr = 1'b0;
  logic [2:0]  phase;
  logic [4:0]  obs_n;
  logic [4:0]  exp_n;
  logic        err;
  logic [1:0]  err_code;
  logic        err_flag;
  logic [7:0]  seq_cnt;
  logic [7:0]  kick_cnt;
  logic [7:0]  err_cnt;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  lamp_seq_monitor #(.MX_LP(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lamp     (lamp),
    .flick    (flick),
    .clr      (clr),
    .phase    (phase),
    .obs_n    (obs_n),
    .exp_n    (exp_n),
    .err      (err),
    .err_code (err_code),
    .err_flag (err_flag),
    .seq_cnt  (seq_cnt),
    .kick_cnt (kick_cnt),
    .err_cnt  (err_cnt)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case something stalls the stimulus.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  // Sequence expressed as legs: odd phases climb to a peak, even phases
  // fall to a floor; what happens at a floor depends on the leg.
  int peak   [8] = '{0, 16, 0, 11, 0, 6, 0, 0};
  int floor_l[8] = '{0, 0, 6, 0, 0, 0, 0, 0};
  int m_phase, m_exp, m_obs, m_err, m_code, m_flag, m_seq, m_kick, m_ecnt;

  function automatic logic [15:0] therm(input int n);
    logic [16:0] t;
    t = (17'd1 << n) - 17'd1;
    return t[15:0];
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_exp = 0; m_obs = 0; m_err = 0; m_code = 0;
    m_flag = 0;  m_seq = 0; m_kick = 0; m_ecnt = 0;
  endtask

  task automatic model_step(input logic [15:0] l, input logic f, input logic c);
    int n, nph, nexp;
    bit shp, stp, kick, seq;
    n    = $countones(l);
    shp  = (m_phase != 7) && (l != therm(n));
    stp  = (m_phase != 7) && (n != m_exp);
    kick = 0;
    seq  = 0;
    m_obs = n;
    m_err = (shp || stp) ? 1 : 0;
    nph  = m_phase;
    nexp = m_exp;
    if (m_err != 0) begin
      m_code = (stp ? 2 : 0) + (shp ? 1 : 0);
      m_flag = 1;
      m_ecnt = c ? 1 : sat(m_ecnt + 1);
      nph  = 7;
      nexp = 0;
    end else begin
      if (m_phase == 0) begin
        nph  = f ? 1 : 0;
        nexp = f ? 1 : 0;
      end else if (m_phase == 7) begin
        if (l == 16'h0000) begin nph = 0; nexp = 0; end
      end else if (m_phase % 2 == 1) begin
        if (n == peak[m_phase]) begin nph = m_phase + 1; nexp = n - 1; end
        else nexp = n + 1;
      end else begin
        if (n == floor_l[m_phase]) begin
          if (m_phase == 2) begin nexp = 7; kick = f; nph = f ? 1 : 3; end
          else if (m_phase == 4) begin nexp = 1; kick = f; nph = f ? 3 : 5; end
          else begin nexp = 0; nph = 0; seq = 1; end
        end else if (m_phase == 4 && n == 5 && f) begin
          nph = 3; nexp = 6; kick = 1;
        end else begin
          nexp = n - 1;
        end
      end
      if (c) begin m_code = 0; m_flag = 0; m_ecnt = 0; end
    end
    m_seq   = c ? 0 : (seq ? sat(m_seq + 1) : m_seq);
    m_kick  = c ? 0 : (kick ? sat(m_kick + 1) : m_kick);
    m_phase = nph;
    m_exp   = nexp;
  endtask

  function automatic logic [63:0] model_pack();
    return {23'b0, 3'(m_phase), 5'(m_obs), 5'(m_exp), 1'(m_err), 2'(m_code),
            1'(m_flag), 8'(m_seq), 8'(m_kick), 8'(m_ecnt)};
  endfunction

  function automatic logic [63:0] dut_pack();
    return {23'b0, phase, obs_n, exp_n, err, err_code, err_flag,
            seq_cnt, kick_cnt, err_cnt};
  endfunction

  // ---------------- helpers ----------------
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Drive one sample, let the edge take it, and settle 1 ns past the edge.
  task automatic applyStimulus(input logic [15:0] l, input logic f, input logic c);
    lamp  = l;
    flick = f;
    clr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    lamp = '0; flick = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_leg(input int a, input int b);
    if (a <= b) for (int n = a; n <= b; n++) applyStimulus(therm(n), 1'b0, 1'b0);
    else        for (int n = a; n >= b; n--) applyStimulus(therm(n), 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [15:0] lamp;
    logic        flick;
    logic [2:0]  ph;
    logic [4:0]  obs;
    logic [4:0]  en;
  } vec_t;

  vec_t tbl[$];

  function automatic void add_row(input int n, input logic f, input int ph, input int en);
    vec_t v;
    v.lamp = therm(n); v.flick = f; v.ph = 3'(ph); v.obs = 5'(n); v.en = 5'(en);
    tbl.push_back(v);
  endfunction

  initial begin
    // Golden no-flick sequence with hand-derived phase/prediction per row.
    add_row(0, 1'b1, 1, 1);
    for (int n = 1; n <= 15; n++)  add_row(n, 1'b0, 1, n + 1);
    add_row(16, 1'b0, 2, 15);
    for (int n = 15; n >= 7; n--)  add_row(n, 1'b0, 2, n - 1);
    add_row(6, 1'b0, 3, 7);
    for (int n = 7; n <= 10; n++)  add_row(n, 1'b0, 3, n + 1);
    add_row(11, 1'b0, 4, 10);
    for (int n = 10; n >= 1; n--)  add_row(n, 1'b0, 4, n - 1);
    add_row(0, 1'b0, 5, 1);
    for (int n = 1; n <= 5; n++)   add_row(n, 1'b0, 5, n + 1);
    add_row(6, 1'b0, 6, 5);
    for (int n = 5; n >= 1; n--)   add_row(n, 1'b0, 6, n - 1);
    add_row(0, 1'b0, 0, 0);

    // Reset held: all outputs zero before and across edges with busy inputs.
    #2;
    checkOutput("reset_initial", dut_pack(), 64'd0);
    lamp = 16'hABCD; flick = 1'b1; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_held", dut_pack(), 64'd0);

    // Quiet bus in IDLE stays clean.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'h0000, 1'b0, 1'b0);
      checkOutput("idle_quiet", dut_pack(), 64'd0);
    end

    // Golden sequence from the table.
    foreach (tbl[i]) begin
      applyStimulus(tbl[i].lamp, tbl[i].flick, 1'b0);
      checkOutput("golden_row", {40'd0, tbl[i].ph, tbl[i].obs, tbl[i].en, err},
                  {40'd0, tbl[i].ph, tbl[i].obs, tbl[i].en, 1'b0});
    end
    checkOutput("golden_counts", {40'd0, seq_cnt, kick_cnt, err_cnt, err_flag},
                {40'd0, 8'd1, 8'd0, 8'd0, 1'b0});

    // Kickback at the bottom of leg A, then clr alone and clr vs kickback.
    do_reset();
    applyStimulus(16'h0000, 1'b1, 1'b0);
    run_leg(1, 16);
    run_leg(15, 7);
    applyStimulus(16'h003F, 1'b1, 1'b0);
    checkOutput("kick_A", {40'd0, phase, exp_n, kick_cnt}, {40'd0, 3'd1, 5'd7, 8'd1});
    applyStimulus(16'h007F, 1'b0, 1'b0);
    checkOutput("kick_A_next", {40'd0, phase, exp_n, err}, {40'd0, 3'd1, 5'd8, 1'b0});
    applyStimulus(16'h00FF, 1'b0, 1'b1);
    checkOutput("clr_keeps_phase", {40'd0, phase, exp_n, kick_cnt, err},
                {40'd0, 3'd1, 5'd9, 8'd0, 1'b0});
    run_leg(9, 16);
    run_leg(15, 7);
    applyStimulus(16'h003F, 1'b1, 1'b1);
    checkOutput("clr_beats_kick", {40'd0, phase, exp_n, kick_cnt}, {40'd0, 3'd1, 5'd7, 8'd0});

    // Shape error, recovery through SYNC, sticky flag and held code.
    do_reset();
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0005, 1'b0, 1'b0);
    checkOutput("shape_err", {40'd0, err, err_code, phase, err_flag, err_cnt},
                {40'd0, 1'b1, 2'b01, 3'd7, 1'b1, 8'd1});
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("sync_exit", {40'd0, err, err_code, phase, err_flag},
                {40'd0, 1'b0, 2'b01, 3'd0, 1'b1});

    // Step error: count jumps from 3 to 5 lamps.
    do_reset();
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0003, 1'b0, 1'b0);
    applyStimulus(16'h0007, 1'b0, 1'b0);
    applyStimulus(16'h001F, 1'b0, 1'b0);
    checkOutput("step_err", {40'd0, err, err_code, phase, err_cnt},
                {40'd0, 1'b1, 2'b10, 3'd7, 8'd1});

    // First sample after reset is checked against zero; then saturate err_cnt.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(16'h0001, 1'b0, 1'b0);
      if (i == 0)
        checkOutput("first_sample", {40'd0, err, err_code, obs_n},
                    {40'd0, 1'b1, 2'b10, 5'd1});
      applyStimulus(16'h0000, 1'b0, 1'b0);
    end
    checkOutput("err_saturate", {40'd0, err_cnt, err_flag}, {40'd0, 8'd255, 1'b1});
    // Error coincident with clr still reports, count restarts at one.
    applyStimulus(16'h0003, 1'b0, 1'b1);
    checkOutput("clr_with_err", {40'd0, err, err_flag, err_cnt},
                {40'd0, 1'b1, 1'b1, 8'd1});
    applyStimulus(16'h0000, 1'b0, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("clr_plain", {40'd0, err_code, err_flag, err_cnt, phase},
                {40'd0, 2'b00, 1'b0, 8'd0, 3'd0});

    // Asynchronous reset in the middle of leg B.
    do_reset();
    applyStimulus(16'h0000, 1'b1, 1'b0);
    run_leg(1, 16);
    run_leg(15, 6);
    run_leg(7, 9);
    checkOutput("pre_reset_upb", {56'd0, 5'd0, phase}, {56'd0, 5'd0, 3'd3});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", dut_pack(), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0);
    checkOutput("post_reset", {40'd0, phase, err, exp_n}, {40'd0, 3'd0, 1'b0, 5'd0});

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] l;
      logic        f, c;
      int          r;
      r = $urandom_range(0, 99);
      if (m_phase == 7)  l = (r < 60) ? 16'h0000 : therm($urandom_range(0, 16));
      else if (r < 90)   l = therm(m_exp);
      else if (r < 95)   l = therm($urandom_range(0, 16));
      else               l = 16'($urandom);
      f = ($urandom_range(0, 3) == 0);
      c = ($urandom_range(0, 49) == 0);
      applyStimulus(l, f, c);
      model_step(l, f, c);
      checkOutput("random", dut_pack(), model_pack());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
